// File: rtl/tcm_pw_check_master_if.sv
// Avalon-MM port bundle for the TCM second port: address/control/data out of the
// master, read data back from the memory.
interface tcm_pw_check_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_clken;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable,
           avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable,
           avm_writedata, avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/tcm_pw_check_master.sv
// Constant-time password check: reads N stored words from the TCM, compares them
// against a candidate stream, writes a status word back and reports pass/fail.
module tcm_pw_check_master #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [4:0]           word_count,
  input  logic                 cand_valid,
  input  logic [DATA_W-1:0]    cand_data,
  output logic                 cand_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [15:0]          attempts,
  tcm_pw_check_master_if.master avm
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_CMP, S_WR_STATUS, S_DONE
  } state_t;

  localparam logic [4:0] MAX_WC = 5'(MAX_WORDS);
  localparam logic [1:0] LAT    = 2'(RD_LAT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [4:0]          wc_q, wc_d;
  logic [4:0]          idx_q, idx_d;
  logic                mismatch_q, mismatch_d;
  logic [1:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   stored_q, stored_d;
  logic                cand_ready_q, cand_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                match_q, match_d;
  logic [15:0]         attempts_q, attempts_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                clken_q, clken_d;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    wc_d         = wc_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    lat_d        = lat_q;
    stored_d     = stored_q;
    cand_ready_d = cand_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    match_d      = match_q;
    attempts_d   = attempts_q;
    addr_d       = addr_q;
    cs_d         = 1'b0;
    wr_d         = 1'b0;
    be_d         = 4'h0;
    wdata_d      = wdata_q;
    clken_d      = 1'b1;

    // Outputs are registered, so each transition sets the bus values of the
    // state being entered.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          wc_d       = word_count;
          idx_d      = 5'd0;
          mismatch_d = 1'b0;
          busy_d     = 1'b1;
          match_d    = 1'b0;
          if (word_count == 5'd0 || word_count > MAX_WC) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_ISSUE;
            cs_d    = 1'b1;
            be_d    = 4'hF;
            addr_d  = base_addr;
          end
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        lat_d   = 2'd1;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT) begin
          stored_d     = avm.avm_readdata;
          state_d      = S_CMP;
          cand_ready_d = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_CMP: begin
        // No early exit on mismatch: every word is read and consumed.
        if (cand_valid && cand_ready_q) begin
          cand_ready_d = 1'b0;
          mismatch_d   = mismatch_q | (stored_q != cand_data);
          if (idx_q == wc_q - 5'd1) begin
            state_d    = S_WR_STATUS;
            cs_d       = 1'b1;
            wr_d       = 1'b1;
            be_d       = 4'hF;
            addr_d     = base_q + ADDR_W'(wc_q);
            attempts_d = sat_inc16(attempts_q);
            wdata_d    = DATA_W'({attempts_d, 15'b0, ~mismatch_d});
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_RD_ISSUE;
            cs_d    = 1'b1;
            be_d    = 4'hF;
            addr_d  = base_q + ADDR_W'(idx_q + 5'd1);
          end
        end
      end
      S_WR_STATUS: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        match_d = ~mismatch_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      wc_q         <= '0;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      lat_q        <= '0;
      cand_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      attempts_q   <= '0;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      be_q         <= 4'h0;
      wdata_q      <= '0;
      clken_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      wc_q         <= wc_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      lat_q        <= lat_d;
      cand_ready_q <= cand_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      match_q      <= match_d;
      attempts_q   <= attempts_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      clken_q      <= clken_d;
    end
  end

  // Captured read word is pure data and only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    stored_q <= stored_d;
  end

  assign cand_ready         = cand_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign match              = match_q;
  assign attempts           = attempts_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_clken      = clken_q;

endmodule

// File: tb/tb_tcm_pw_check_master.sv
// Directed bench for tcm_pw_check_master with a behavioural single-cycle-latency
// TCM model and hand-computed expectations.
module tb_tcm_pw_check_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [4:0]  word_count = '0;
  logic        cand_valid = 1'b0;
  logic [31:0] cand_data = '0;
  logic        cand_ready, busy, done, match;
  logic [15:0] attempts;

  tcm_pw_check_master_if #(.ADDR_W(9), .DATA_W(32)) tif ();

  tcm_pw_check_master #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1), .MAX_WORDS(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .cand_valid (cand_valid),
    .cand_data  (cand_data),
    .cand_ready (cand_ready),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .attempts   (attempts),
    .avm        (tif.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TCM model: one-cycle registered read, plus access logging.
  logic [31:0] mem [512];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          rd_n = 0, wr_n = 0, cs_cnt = 0;
  int          rd_log [64];
  logic [8:0]  wr_addr_last = '0;
  logic [31:0] wr_data_last = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (tif.avm_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      if (tif.avm_write) begin
        mem[tif.avm_address] <= tif.avm_writedata;
        wr_n         <= wr_n + 1;
        wr_addr_last <= tif.avm_address;
        wr_data_last <= tif.avm_writedata;
      end else begin
        rd_log[rd_n % 64]  <= int'(tif.avm_address);
        rd_n               <= rd_n + 1;
        tif.avm_readdata   <= mem[tif.avm_address];
      end
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_match"},  32'(match), 32'd0);
    chk({tag, "_att"},    32'(attempts), 32'd0);
    chk({tag, "_rdy"},    32'(cand_ready), 32'd0);
    chk({tag, "_cs"},     32'(tif.avm_chipselect), 32'd0);
    chk({tag, "_wr"},     32'(tif.avm_write), 32'd0);
    chk({tag, "_be"},     32'(tif.avm_byteenable), 32'd0);
    chk({tag, "_addr"},   32'(tif.avm_address), 32'd0);
    chk({tag, "_wdata"},  tif.avm_writedata, 32'd0);
    chk({tag, "_clken"},  32'(tif.avm_clken), 32'd1);
  endtask

  // Runs one check; candidate words are offered with 'gap' idle cycles before
  // each, and an optional stray start is pulsed mid-check.
  task automatic run_check(input logic [8:0] b, input logic [4:0] n,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int gap, input bit poke,
                           output int lat, output bit stall);
    logic [31:0] w [3];
    int t0, ptr, gap_left;
    bit pend;
    w[0] = w0; w[1] = w1; w[2] = w2;
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = n;
    t0 = cyc; ptr = 0; gap_left = gap; pend = 1'b0; lat = -1; stall = 1'b0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && it == 4) begin
        start = 1'b1; base_addr = 9'd200; word_count = 5'd5;
      end
      if (pend) begin ptr++; gap_left = gap; pend = 1'b0; end
      if (done) begin lat = cyc - t0; break; end
      if (ptr < int'(n) && ptr < 3 && gap_left == 0) begin
        cand_valid = 1'b1; cand_data = w[ptr];
      end else begin
        cand_valid = 1'b0;
        if (gap_left > 0) gap_left--;
        if (cand_ready) stall = 1'b1;
      end
      pend = cand_valid && cand_ready;
    end
    start = 1'b0; cand_valid = 1'b0;
    chk("done_seen", 32'(lat >= 0), 32'd1);
  endtask

  task automatic chk_result(input string tag, input int rd0, input int wr0,
                            input int a0, input int a1, input int a2,
                            input logic [8:0] wa, input logic [31:0] wd,
                            input logic m, input logic [15:0] att);
    chk({tag, "_rdn"},   32'(rd_n - rd0), 32'd3);
    chk({tag, "_rd0"},   32'(rd_log[rd0 % 64]), 32'(a0));
    chk({tag, "_rd1"},   32'(rd_log[(rd0 + 1) % 64]), 32'(a1));
    chk({tag, "_rd2"},   32'(rd_log[(rd0 + 2) % 64]), 32'(a2));
    chk({tag, "_wrn"},   32'(wr_n - wr0), 32'd1);
    chk({tag, "_wra"},   32'(wr_addr_last), 32'(wa));
    chk({tag, "_wrd"},   wr_data_last, wd);
    chk({tag, "_mem"},   mem[wa], wd);
    chk({tag, "_match"}, 32'(match), 32'(m));
    chk({tag, "_att"},   32'(attempts), 32'(att));
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  localparam logic [31:0] PW0 = 32'h61626364;
  localparam logic [31:0] PW1 = 32'h65666768;
  localparam logic [31:0] PW2 = 32'h00000031;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, rd0, wr0, cs0;
    bit stall;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    preload(9'd16, PW0);
    preload(9'd17, PW1);
    preload(9'd18, PW2);
    preload(9'd19, 32'h0);
    preload(9'd510, PW0);
    preload(9'd511, PW1);
    preload(9'd0, PW2);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching password, cand_valid held high.
    rd0 = rd_n; wr0 = wr_n;
    run_check(9'd16, 5'd3, PW0, PW1, PW2, 0, 1'b0, lat, stall);
    chk("t1_lat", 32'(lat), 32'd11);
    chk_result("t1", rd0, wr0, 16, 17, 18, 9'd19, 32'h0001_0001, 1'b1, 16'd1);

    // Second word wrong; a stray start mid-check must change nothing.
    rd0 = rd_n; wr0 = wr_n;
    run_check(9'd16, 5'd3, PW0, 32'h65666769, PW2, 0, 1'b1, lat, stall);
    chk("t2_lat", 32'(lat), 32'd11);
    chk_result("t2", rd0, wr0, 16, 17, 18, 9'd19, 32'h0002_0000, 1'b0, 16'd2);

    // Address wrap at the top of the TCM.
    rd0 = rd_n; wr0 = wr_n;
    run_check(9'd510, 5'd3, PW0, PW1, PW2, 0, 1'b0, lat, stall);
    chk_result("t3", rd0, wr0, 510, 511, 0, 9'd1, 32'h0003_0001, 1'b1, 16'd3);

    // Candidate gaps: stall in CMP, same result, no extra accesses.
    rd0 = rd_n; wr0 = wr_n; cs0 = cs_cnt;
    run_check(9'd16, 5'd3, PW0, PW1, PW2, 4, 1'b0, lat, stall);
    chk("t4_stall", 32'(stall), 32'd1);
    chk("t4_cs", 32'(cs_cnt - cs0), 32'd4);
    chk_result("t4", rd0, wr0, 16, 17, 18, 9'd19, 32'h0004_0001, 1'b1, 16'd4);

    // Illegal lengths: fast done, no memory access, attempts unchanged.
    cs0 = cs_cnt;
    run_check(9'd16, 5'd0, PW0, PW1, PW2, 0, 1'b0, lat, stall);
    chk("t5_lat_le2", 32'(lat >= 1 && lat <= 2), 32'd1);
    chk("t5_match", 32'(match), 32'd0);
    chk("t5_att", 32'(attempts), 32'd4);
    chk("t5_cs", 32'(cs_cnt - cs0), 32'd0);

    cs0 = cs_cnt;
    run_check(9'd16, 5'd17, PW0, PW1, PW2, 0, 1'b0, lat, stall);
    chk("t6_lat_le2", 32'(lat >= 1 && lat <= 2), 32'd1);
    chk("t6_match", 32'(match), 32'd0);
    chk("t6_att", 32'(attempts), 32'd4);
    chk("t6_cs", 32'(cs_cnt - cs0), 32'd0);
    @(negedge clk);
    chk("t6_busy_after", 32'(busy), 32'd0);

    // Reset during the second RD_WAIT.
    rd0 = rd_n; wr0 = wr_n; cs0 = cs_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 9'd16; word_count = 5'd3;
    cand_valid = 1'b1; cand_data = PW0;
    lat = -1;
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_n - rd0 == 2) begin lat = it; break; end
    end
    chk("t7_reached_rdwait2", 32'(lat >= 0), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t7_rst");
    cand_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_no_wr", 32'(wr_n - wr0), 32'd0);
    chk("t7_cs", 32'(cs_cnt - cs0), 32'd2);
    chk("t7_busy", 32'(busy), 32'd0);

    // Fresh check after reset behaves like the first one.
    rd0 = rd_n; wr0 = wr_n;
    run_check(9'd16, 5'd3, PW0, PW1, PW2, 0, 1'b0, lat, stall);
    chk("t8_lat", 32'(lat), 32'd11);
    chk_result("t8", rd0, wr0, 16, 17, 18, 9'd19, 32'h0001_0001, 1'b1, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
